// File: rtl/sd_req_arbiter_if.sv
// Bundle of requester-side and hps_io-side signals of the virtual-disk arbiter.
// master = environment (disk controllers + hps_io), slave = sd_req_arbiter.
interface sd_req_arbiter_if;
  logic [3:0]   req_rd;
  logic [3:0]   req_wr;
  logic [127:0] req_lba;
  logic [31:0]  req_din;
  logic [3:0]   done;
  logic [3:0]   err;
  logic [3:0]   buff_wr;
  logic         busy;
  logic [31:0]  sd_lba;
  logic [3:0]   sd_rd;
  logic [3:0]   sd_wr;
  logic         sd_ack;
  logic         sd_buff_wr;
  logic [7:0]   sd_buff_din;

  modport master (
    output req_rd, req_wr, req_lba, req_din, sd_ack, sd_buff_wr,
    input  done, err, buff_wr, busy, sd_lba, sd_rd, sd_wr, sd_buff_din
  );

  modport slave (
    input  req_rd, req_wr, req_lba, req_din, sd_ack, sd_buff_wr,
    output done, err, buff_wr, busy, sd_lba, sd_rd, sd_wr, sd_buff_din
  );
endinterface

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing the single hps_io sd_* channel among FDD0, FDD1,
// SASI and NVRAM, with rd/wr->ack handshake, buffer routing and an ack watchdog.
module sd_req_arbiter #(
  parameter int TOUT_W = 24
) (
  input logic             cpuclk,
  input logic             rstn,
  sd_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic [3:0]        pend_rd_r;
  logic [3:0]        pend_wr_r;
  logic [1:0]        ptr_r;
  logic [1:0]        gnt_r;
  logic [TOUT_W-1:0] wd_r;
  logic [31:0]       sd_lba_r;
  logic [3:0]        sd_rd_r;
  logic [3:0]        sd_wr_r;
  logic [3:0]        done_r;
  logic [3:0]        err_r;
  logic              busy_r;

  logic [3:0]        elig_s;
  logic              sel_vld_s;
  logic [1:0]        sel_s;
  logic [1:0]        idx_s;
  logic              issue_s;
  logic              issue_wr_s;
  logic [3:0]        clr_rd_s;
  logic [3:0]        clr_wr_s;
  logic [TOUT_W-1:0] wd_inc_s;
  logic              tout_s;

  function automatic logic [3:0] dec2(input logic [1:0] i);
    dec2 = 4'b0001 << i;
  endfunction

  // Round-robin pick: scan from the highest offset down so the nearest to ptr wins.
  always_comb begin
    elig_s    = pend_rd_r | pend_wr_r;
    sel_vld_s = 1'b0;
    sel_s     = ptr_r;
    idx_s     = ptr_r;
    for (int k = 3; k >= 0; k--) begin
      idx_s = ptr_r + 2'(k);
      if (elig_s[idx_s]) begin
        sel_vld_s = 1'b1;
        sel_s     = idx_s;
      end else begin
        sel_vld_s = sel_vld_s;
      end
    end
  end

  // Issue decode: write wins over read when both are pending for the winner.
  always_comb begin
    issue_s    = (state_r == IDLE) && sel_vld_s;
    issue_wr_s = pend_wr_r[sel_s];
    clr_rd_s   = 4'b0000;
    clr_wr_s   = 4'b0000;
    if (issue_s) begin
      if (issue_wr_s) begin
        clr_wr_s = dec2(sel_s);
      end else begin
        clr_rd_s = dec2(sel_s);
      end
    end else begin
      clr_rd_s = 4'b0000;
    end
    wd_inc_s = wd_r + {{(TOUT_W-1){1'b0}}, 1'b1};
    tout_s   = &wd_inc_s;
  end

  // Pending latches; a pulse in the issue cycle re-sets the bit being cleared.
  always_ff @(posedge cpuclk or negedge rstn) begin
    if (!rstn) begin
      pend_rd_r <= 4'b0000;
      pend_wr_r <= 4'b0000;
    end else begin
      pend_rd_r <= (pend_rd_r & ~clr_rd_s) | bus.req_rd;
      pend_wr_r <= (pend_wr_r & ~clr_wr_s) | bus.req_wr;
    end
  end

  // Handshake FSM with registered hps_io strobes and completion pulses.
  always_ff @(posedge cpuclk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= IDLE;
      ptr_r    <= 2'd0;
      gnt_r    <= 2'd0;
      wd_r     <= '0;
      sd_lba_r <= 32'h0000_0000;
      sd_rd_r  <= 4'b0000;
      sd_wr_r  <= 4'b0000;
      done_r   <= 4'b0000;
      err_r    <= 4'b0000;
      busy_r   <= 1'b0;
    end else begin
      done_r <= 4'b0000;
      err_r  <= 4'b0000;
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            gnt_r    <= sel_s;
            sd_lba_r <= bus.req_lba[{sel_s, 5'b00000} +: 32];
            if (issue_wr_s) begin
              sd_wr_r <= dec2(sel_s);
            end else begin
              sd_rd_r <= dec2(sel_s);
            end
            wd_r    <= '0;
            busy_r  <= 1'b1;
            state_r <= ISSUE;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ISSUE: begin
          if (bus.sd_ack) begin
            sd_rd_r <= 4'b0000;
            sd_wr_r <= 4'b0000;
            wd_r    <= '0;
            state_r <= XFER;
          end else if (tout_s) begin
            sd_rd_r <= 4'b0000;
            sd_wr_r <= 4'b0000;
            done_r  <= dec2(gnt_r);
            err_r   <= dec2(gnt_r);
            state_r <= DONE;
          end else begin
            wd_r    <= wd_inc_s;
          end
        end
        XFER: begin
          if (!bus.sd_ack) begin
            done_r  <= dec2(gnt_r);
            state_r <= DONE;
          end else if (tout_s) begin
            done_r  <= dec2(gnt_r);
            err_r   <= dec2(gnt_r);
            state_r <= DONE;
          end else begin
            wd_r    <= wd_inc_s;
          end
        end
        DONE: begin
          ptr_r   <= gnt_r + 2'd1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          sd_rd_r <= 4'b0000;
          sd_wr_r <= 4'b0000;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.sd_lba      = sd_lba_r;
  assign bus.sd_rd       = sd_rd_r;
  assign bus.sd_wr       = sd_wr_r;
  assign bus.done        = done_r;
  assign bus.err         = err_r;
  assign bus.busy        = busy_r;
  assign bus.buff_wr     = {4{bus.sd_buff_wr && (state_r == XFER)}} & dec2(gnt_r);
  assign bus.sd_buff_din = bus.req_din[{gnt_r, 3'b000} +: 8];

endmodule
